// File: rtl/inst_fetch_unit_pkg.sv
// Shared fetch/cache definitions: datapath width, fetch stride, FSM encodings.
package inst_fetch_unit_pkg;

   localparam int              XLEN        = 32;
   localparam logic [XLEN-1:0] INST_STRIDE = 32'd4;
   localparam int              ENTRY_W     = 2 * XLEN;

   typedef enum logic [1:0] {
      ST_REQ      = 2'd0,
      ST_WAIT_RSP = 2'd1,
      ST_DRAIN    = 2'd2
   } fetch_state_e;

   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
      return {pc[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: circular FIFO with flush, combinational head from registered storage.
module fetch_fifo #(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 64,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Flush wins over push/pop issued in the same cycle.
   assign do_push = push && !flush && (count_q != CNT_W'(DEPTH));
   assign do_pop  = pop  && !flush && (count_q != '0);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
         if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: one outstanding I-cache request, slot reserved in the buffer at issue.
module inst_fetch_unit
   import inst_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        to_icache_req_valid,
   output logic [31:0] to_icache_req_addr,
   input  logic        from_icache_req_ready,
   input  logic        from_icache_rsp_valid,
   input  logic [31:0] from_icache_rsp_data,
   output logic        to_icache_rsp_ready,
   output logic        to_dec_valid,
   output logic [31:0] to_dec_inst,
   output logic [31:0] to_dec_pc,
   input  logic        from_dec_ready
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   fetch_state_e       state_q, state_d;
   logic [XLEN-1:0]    fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0]    req_addr_q, req_addr_d;
   logic               req_hs, rsp_hs, dec_hs;
   logic               outstanding_next;
   logic               fifo_push, fifo_flush;
   logic [ENTRY_W-1:0] fifo_rdata;
   logic [CNT_W-1:0]   fifo_count;
   logic               unused_pc_lsbs;

   assign unused_pc_lsbs = ^redirect_pc[1:0];

   assign req_hs = to_icache_req_valid && from_icache_req_ready;
   assign rsp_hs = to_icache_rsp_ready && from_icache_rsp_valid;
   assign dec_hs = to_dec_valid && from_dec_ready;

   // Outputs are gated by rst so they drop the moment reset asserts.
   assign to_icache_req_valid = rst && (state_q == ST_REQ) && (fifo_count < CNT_W'(FIFO_DEPTH));
   assign to_icache_rsp_ready = rst && (state_q != ST_REQ);
   assign to_icache_req_addr  = !rst ? '0 : ((state_q == ST_REQ) ? fetch_pc_q : req_addr_q);

   assign to_dec_valid = rst && (fifo_count != '0);
   assign to_dec_pc    = to_dec_valid ? fifo_rdata[ENTRY_W-1:XLEN] : '0;
   assign to_dec_inst  = to_dec_valid ? fifo_rdata[XLEN-1:0]       : '0;

   // Whether a request is still in flight after this edge.
   assign outstanding_next = (state_q == ST_REQ) ? req_hs : !rsp_hs;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_addr_d = req_addr_q;
      fifo_push  = 1'b0;
      fifo_flush = 1'b0;
      case (state_q)
         ST_REQ: begin
            if (req_hs) begin
               state_d    = ST_WAIT_RSP;
               req_addr_d = fetch_pc_q;
               fetch_pc_d = fetch_pc_q + INST_STRIDE;
            end
         end
         ST_WAIT_RSP: begin
            if (rsp_hs) begin
               fifo_push = 1'b1;
               state_d   = ST_REQ;
            end
         end
         ST_DRAIN: begin
            if (rsp_hs) state_d = ST_REQ;
         end
         default: state_d = ST_REQ;
      endcase
      if (redirect_valid) begin
         fifo_push  = 1'b0;
         fifo_flush = 1'b1;
         fetch_pc_d = align_pc(redirect_pc);
         state_d    = outstanding_next ? ST_DRAIN : ST_REQ;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_REQ;
         fetch_pc_q <= RESET_PC;
         req_addr_q <= RESET_PC;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_addr_q <= req_addr_d;
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (dec_hs),
      .flush (fifo_flush),
      .wdata ({req_addr_q, from_icache_rsp_data}),
      .rdata (fifo_rdata),
      .count (fifo_count)
   );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a blocking single-response I-cache driven from tasks.
module tb_inst_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        to_icache_req_valid;
   logic [31:0] to_icache_req_addr;
   logic        from_icache_req_ready = 1'b0;
   logic        from_icache_rsp_valid = 1'b0;
   logic [31:0] from_icache_rsp_data = '0;
   logic        to_icache_rsp_ready;
   logic        to_dec_valid;
   logic [31:0] to_dec_inst;
   logic [31:0] to_dec_pc;
   logic        from_dec_ready = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   inst_fetch_unit #(
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (4)
   ) dut (
      .clk                   (clk),
      .rst                   (rst),
      .redirect_valid        (redirect_valid),
      .redirect_pc           (redirect_pc),
      .to_icache_req_valid   (to_icache_req_valid),
      .to_icache_req_addr    (to_icache_req_addr),
      .from_icache_req_ready (from_icache_req_ready),
      .from_icache_rsp_valid (from_icache_rsp_valid),
      .from_icache_rsp_data  (from_icache_rsp_data),
      .to_icache_rsp_ready   (to_icache_rsp_ready),
      .to_dec_valid          (to_dec_valid),
      .to_dec_inst           (to_dec_inst),
      .to_dec_pc             (to_dec_pc),
      .from_dec_ready        (from_dec_ready)
   );

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return a ^ 32'hDEAD_BEEF;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
      else             n_pass++;
   endtask

   task automatic issue(input logic [31:0] a);
      chk("req_valid", {31'b0, to_icache_req_valid}, 32'd1);
      chk("req_addr", to_icache_req_addr, a);
      from_icache_req_ready = 1'b1;
      @(negedge clk);
      from_icache_req_ready = 1'b0;
   endtask

   task automatic respond(input logic [31:0] a, input int delay);
      for (int i = 0; i < delay; i++) begin
         from_icache_req_ready = 1'b1;
         chk("hold_addr", to_icache_req_addr, a);
         chk("no_new_req", {31'b0, to_icache_req_valid}, 32'd0);
         chk("dec_empty_wait", {31'b0, to_dec_valid}, 32'd0);
         @(negedge clk);
      end
      from_icache_req_ready = 1'b0;
      chk("rsp_ready", {31'b0, to_icache_rsp_ready}, 32'd1);
      from_icache_rsp_valid = 1'b1;
      from_icache_rsp_data  = inst_of(a);
      @(negedge clk);
      from_icache_rsp_valid = 1'b0;
      from_icache_rsp_data  = '0;
      $display("rsp addr=%h data=%h delay=%0d", a, inst_of(a), delay);
   endtask

   task automatic check_head(input logic [31:0] a);
      chk("dec_valid", {31'b0, to_dec_valid}, 32'd1);
      chk("dec_pc", to_dec_pc, a);
      chk("dec_inst", to_dec_inst, inst_of(a));
   endtask

   task automatic pop_one();
      from_dec_ready = 1'b1;
      @(negedge clk);
      from_dec_ready = 1'b0;
   endtask

   task automatic redirect(input logic [31:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      @(negedge clk);
      redirect_valid = 1'b0;
      redirect_pc    = '0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_req_valid"}, {31'b0, to_icache_req_valid}, 32'd0);
      chk({tag, "_rsp_ready"}, {31'b0, to_icache_rsp_ready}, 32'd0);
      chk({tag, "_dec_valid"}, {31'b0, to_dec_valid}, 32'd0);
      chk({tag, "_req_addr"}, to_icache_req_addr, 32'd0);
      chk({tag, "_dec_pc"}, to_dec_pc, 32'd0);
      chk({tag, "_dec_inst"}, to_dec_inst, 32'd0);
   endtask

   initial begin
      #2 rst = 1'b0;
      @(negedge clk);
      check_all_zero("reset");
      rst = 1'b1;
      #1;

      // Sequential fetch 0x0, 0x4, 0x8 with 1-cycle responses, decode always ready.
      for (int i = 0; i < 3; i++) begin
         issue(32'(4 * i));
         respond(32'(4 * i), 0);
         check_head(32'(4 * i));
         from_dec_ready = 1'b1;
      end
      @(negedge clk);
      from_dec_ready = 1'b0;
      chk("empty_after_seq", {31'b0, to_dec_valid}, 32'd0);

      // Back-pressure: buffer fills at 4 entries and requests stop until a pop.
      for (int i = 0; i < 4; i++) begin
         issue(32'h0C + 32'(4 * i));
         respond(32'h0C + 32'(4 * i), 0);
      end
      check_head(32'h0C);
      from_icache_req_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("full_no_req", {31'b0, to_icache_req_valid}, 32'd0);
         @(negedge clk);
      end
      from_icache_req_ready = 1'b0;
      pop_one();
      chk("req_after_pop", {31'b0, to_icache_req_valid}, 32'd1);
      chk("addr_after_pop", to_icache_req_addr, 32'h1C);
      from_dec_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         check_head(32'h10 + 32'(4 * k));
         @(negedge clk);
      end
      from_dec_ready = 1'b0;
      chk("empty_after_drain", {31'b0, to_dec_valid}, 32'd0);

      // Redirect while waiting: response discarded, refetch from aligned target.
      redirect(32'h12);
      issue(32'h10);
      redirect(32'h1003);
      chk("drain_no_req", {31'b0, to_icache_req_valid}, 32'd0);
      chk("drain_rsp_ready", {31'b0, to_icache_rsp_ready}, 32'd1);
      chk("drain_dec_valid", {31'b0, to_dec_valid}, 32'd0);
      from_icache_rsp_valid = 1'b1;
      from_icache_rsp_data  = inst_of(32'h10);
      @(negedge clk);
      from_icache_rsp_valid = 1'b0;
      chk("discarded", {31'b0, to_dec_valid}, 32'd0);
      issue(32'h1000);
      respond(32'h1000, 2);
      check_head(32'h1000);
      pop_one();

      // Long response stall keeps the request address stable.
      redirect(32'h40);
      issue(32'h40);
      respond(32'h40, 20);
      check_head(32'h40);
      pop_one();

      // Address wrap at the top of the address space.
      redirect(32'hFFFF_FFFC);
      issue(32'hFFFF_FFFC);
      respond(32'hFFFF_FFFC, 0);
      check_head(32'hFFFF_FFFC);
      issue(32'h0);
      respond(32'h0, 0);
      pop_one();
      check_head(32'h0);
      issue(32'h4);

      // Reset asserted mid-wait with a buffered entry.
      rst = 1'b0;
      #1;
      check_all_zero("async_rst");
      @(negedge clk);
      check_all_zero("held_rst");
      rst = 1'b1;
      #1;
      issue(32'h0);
      respond(32'h0, 0);
      check_head(32'h0);
      pop_one();

      // Redirect coincident with a request handshake counts that request as outstanding.
      chk("pre_coinc_addr", to_icache_req_addr, 32'h4);
      from_icache_req_ready = 1'b1;
      redirect(32'h200);
      from_icache_req_ready = 1'b0;
      chk("coinc_no_req", {31'b0, to_icache_req_valid}, 32'd0);
      chk("coinc_rsp_ready", {31'b0, to_icache_rsp_ready}, 32'd1);
      from_icache_rsp_valid = 1'b1;
      from_icache_rsp_data  = inst_of(32'h4);
      @(negedge clk);
      from_icache_rsp_valid = 1'b0;
      chk("coinc_discard", {31'b0, to_dec_valid}, 32'd0);
      issue(32'h200);
      respond(32'h200, 0);
      check_head(32'h200);
      pop_one();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
